// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RV32I funct3 encodings for loads and stores
//   - FSM state encoding
//   - access_fault(): decides at accept time whether a request may touch memory
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RMW_RD,
        ST_WRITE,
        ST_RESP
    } lsu_state_e;

    // limit is the first illegal byte address; 33 bits so that a 4 GiB
    // memory would still be representable.
    function automatic logic access_fault(input logic        we,
                                          input logic [2:0]  funct3,
                                          input logic [31:0] addr,
                                          input logic [32:0] limit);
        logic legal;
        logic misal;
        legal = 1'b0;
        misal = 1'b0;
        case (funct3)
            F3_B:  legal = 1'b1;
            F3_H:  begin legal = 1'b1; misal = addr[0];    end
            F3_W:  begin legal = 1'b1; misal = |addr[1:0]; end
            F3_BU: legal = !we;
            F3_HU: begin legal = !we;  misal = addr[0];    end
            default: legal = 1'b0;
        endcase
        return !legal || misal || ({1'b0, addr} >= limit);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational data alignment for the load/store unit.
//   word    in  32  memory word as read
//   offs    in   2  byte offset within the word (addr[1:0])
//   funct3  in   3  access size / signedness
//   wdata   in  32  right-aligned store data
//   ld_data out 32  selected and extended load result
//   st_word out 32  word with the addressed byte/half replaced by wdata
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offs,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);

    logic [31:0] shifted;

    always_comb begin
        // little-endian: byte at offset k lives in bits [8k+7:8k]
        shifted = word >> {offs, 3'b000};
        ld_data = '0;
        case (funct3)
            F3_B:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU: ld_data = {24'b0, shifted[7:0]};
            F3_H:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU: ld_data = {16'b0, shifted[15:0]};
            F3_W:  ld_data = shifted;
            default: ld_data = '0;
        endcase
    end

    always_comb begin
        st_word = word;
        case (funct3)
            F3_B:    st_word[{offs, 3'b000} +: 8]     = wdata[7:0];
            F3_H:    st_word[{offs[1], 4'b0000} +: 16] = wdata[15:0];
            F3_W:    st_word = wdata;
            default: st_word = word;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// lsu: RV32I load/store unit driving a word-wide, combinational-read memory.
// Sub-word stores are done as read-modify-write since memory writes whole words.
//   clk, rstb              clock, async active-low reset
//   req_valid/req_ready    request handshake (ready only when idle)
//   req_we/funct3/addr/wdata  request fields
//   resp_valid             one-cycle completion pulse
//   resp_rdata/resp_fault  load result (0 for stores/faults) and fault flag
//   mem_addr/wdata/write/read/rdata  memory port
//
// state     | meaning
// ----------+--------------------------------------------------
// ST_IDLE   | ready for a request; decode and fault check on accept
// ST_LOAD   | read word, extract/extend, register result
// ST_RMW_RD | read word, merge sub-word store data
// ST_WRITE  | write merged word
// ST_RESP   | pulse resp_valid
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_rdata
);

    localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;

    lsu_state_e  state_q,  state_d;
    logic        we_q,     we_d;
    logic [2:0]  f3_q,     f3_d;
    logic [31:0] addr_q,   addr_d;
    logic [31:0] wdata_q,  wdata_d;
    logic [31:0] merged_q, merged_d;
    logic [31:0] rdata_q,  rdata_d;
    logic        fault_q,  fault_d;

    logic [31:0] ld_data;
    logic [31:0] st_word;

    lsu_align u_align (
        .word    (mem_rdata),
        .offs    (addr_q[1:0]),
        .funct3  (f3_q),
        .wdata   (wdata_q),
        .ld_data (ld_data),
        .st_word (st_word)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            f3_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            merged_q <= '0;
            rdata_q  <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            f3_q     <= f3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            merged_q <= merged_d;
            rdata_q  <= rdata_d;
            fault_q  <= fault_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        f3_d     = f3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        merged_d = merged_q;
        rdata_d  = rdata_q;
        fault_d  = fault_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    fault_d = access_fault(req_we, req_funct3, req_addr, ADDR_LIMIT);
                    if (fault_d) begin
                        state_d = ST_RESP;
                    end else if (!req_we) begin
                        state_d = ST_LOAD;
                    end else if (req_funct3 == F3_W) begin
                        merged_d = req_wdata;
                        state_d  = ST_WRITE;
                    end else begin
                        state_d = ST_RMW_RD;
                    end
                end
            end
            ST_LOAD: begin
                rdata_d = ld_data;
                state_d = ST_RESP;
            end
            ST_RMW_RD: begin
                merged_d = st_word;
                state_d  = ST_WRITE;
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Strobes decode straight from state so reset removes them asynchronously.
    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_fault = fault_q;
    assign resp_rdata = we_q ? 32'h0 : rdata_q;
    assign mem_addr   = {addr_q[31:2], 2'b00};
    assign mem_wdata  = merged_q;
    assign mem_write  = (state_q == ST_WRITE);
    assign mem_read   = (state_q == ST_LOAD) || (state_q == ST_RMW_RD);

endmodule
